// File: rtl/uart_pkg.sv
// UART shared types: transmit FSM state encoding and parity helper.
// Used by both the transmit arbiter and the receive side.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_e;

  function automatic logic parity_bit(
    input logic [31:0] d,
    input logic        odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin requester picker with a rotating priority pointer.
// Search starts one past the last winner and wraps modulo NUM_REQ.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  logic [IW-1:0] ptr_q;
  logic          found;

  assign any_o = |req_i;

  always_comb begin
    int k;
    found = 1'b0;
    idx_o = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req_i[k]) begin
        found = 1'b1;
        idx_o = IW'(k);
      end
    end
    gnt_o = found ? (NUM_REQ'(1) << idx_o) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= IW'(NUM_REQ - 1);
    end else if (adv_i && any_o) begin
      ptr_q <= idx_o;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX line between NUM_REQ producers and serialises
// each granted byte as start, data, optional parity and stop bits.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          baud_tick_i,
  input  logic                          tx_en,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          data_order,
  input  logic                          polarity,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          busy_o,
  output logic                          tx_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_tx_state_e        state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  par_q, par_d;
  logic                  pe_q, pe_d;
  logic                  pol_q, pol_d;
  logic [IW-1:0]         gid_q, gid_d;
  logic                  tx_q, line_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;
  logic                  grant;
  logic [DATA_WIDTH-1:0] sel_data, rev_data;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_valid_i),
    .adv_i  (grant),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  assign grant = rst_ni & baud_tick_i & tx_en & arb_any
               & ((state_q == ST_IDLE) | (state_q == ST_STOP));

  assign req_ready_o = {NUM_REQ{grant}} & arb_gnt;

  always_comb begin
    sel_data = req_data_i[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
    for (int i = 0; i < DATA_WIDTH; i++) begin
      rev_data[i] = sel_data[DATA_WIDTH-1-i];
    end
  end

  // MSB-first frames are stored reversed so the shifter always sends bit 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pe_d    = pe_q;
    pol_d   = pol_q;
    gid_d   = gid_q;
    line_d  = 1'b1;
    if (baud_tick_i) begin
      unique case (state_q)
        ST_IDLE: ;
        ST_START: begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
        ST_DATA: begin
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            state_d = pe_q ? ST_PARITY : ST_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
            sh_d  = sh_q >> 1;
          end
        end
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
    if (grant) begin
      state_d = ST_START;
      sh_d    = data_order ? rev_data : sel_data;
      par_d   = parity_bit(32'(sel_data), parity_odd);
      pe_d    = parity_en;
      pol_d   = polarity;
      gid_d   = arb_idx;
    end else if (state_d == ST_IDLE) begin
      pol_d = polarity;
    end
    unique case (state_d)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = sh_d[0];
      ST_PARITY: line_d = par_d;
      default:   line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
      pol_q   <= 1'b0;
      gid_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      pe_q    <= pe_d;
      pol_q   <= pol_d;
      gid_q   <= gid_d;
      tx_q    <= line_d ^ pol_d;
    end
  end

  assign tx_o       = tx_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign grant_id_o = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed checks of uart_tx_arbiter against a
// frame-level reference model (queue of expected line bits per tick).
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           tick, tx_en, parity_en, parity_odd;
  logic           data_order, polarity;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ready;
  logic [1:0]     gid;
  logic           busy, tx;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .baud_tick_i (tick),
    .tx_en       (tx_en),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .data_order  (data_order),
    .polarity    (polarity),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (ready),
    .grant_id_o  (gid),
    .busy_o      (busy),
    .tx_o        (tx)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit mq[$];
  bit mpol;
  int mptr;
  int mgid;
  int tick_cnt;
  bit obs[$];
  int grants[$];
  int gtick[$];
  bit refill;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void push_frame(input logic [7:0] d, input bit pe,
                                     input bit po, input bit ord);
    mq.push_back(1'b0);
    for (int i = 0; i < W; i++) mq.push_back(ord ? d[W-1-i] : d[i]);
    if (pe) mq.push_back((^d) ^ po);
    mq.push_back(1'b1);
  endfunction

  function automatic int frame_val(input int start, input int n);
    int v;
    if (obs.size() < start + n) return -1;
    v = 0;
    for (int i = 0; i < n; i++) v = (v << 1) | int'(obs[start+i]);
    return v;
  endfunction

  // one clock: inputs already driven at the preceding negedge
  task automatic cycle();
    int w;
    bit t;
    logic [N-1:0] exp_rdy;
    t = tick;
    #1;
    w = -1;
    if (t) begin
      if (mq.size() > 0) void'(mq.pop_front());
      if (mq.size() == 0 && tx_en && (|req_valid)) begin
        for (int i = 1; i <= N && w < 0; i++) begin
          if (req_valid[(mptr+i)%N]) w = (mptr + i) % N;
        end
      end
    end
    exp_rdy = (w >= 0) ? N'(1 << w) : '0;
    chk("ready", 32'(ready), 32'(exp_rdy));
    if (w >= 0) begin
      push_frame(req_data[w*W +: W], parity_en, parity_odd, data_order);
      mpol = polarity;
      mgid = w;
      mptr = w;
      grants.push_back(w);
      gtick.push_back(tick_cnt);
    end
    @(negedge clk);
    if (t) begin
      obs.push_back(tx);
      tick_cnt++;
    end
    chk("tx", 32'(tx), 32'(mq.size() > 0 ? (mq[0] ^ mpol) : (1'b1 ^ polarity)));
    chk("busy", 32'(busy), 32'(mq.size() > 0));
    chk("grant_id", 32'(gid), 32'(mgid));
    if (w >= 0) begin
      if (refill) req_data[w*W +: W] = 8'($urandom);
      else req_valid[w] = 1'b0;
    end
  endtask

  task automatic run_ticks(input int nt, input int per);
    for (int i = 0; i < nt * per; i++) begin
      tick = ((i % per) == per - 1);
      cycle();
    end
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick  = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_gid", 32'(gid), 32'd0);
    mq.delete();
    mptr = N - 1;
    mgid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    bit ok;
    rst_n = 1'b0;
    tick = 0; tx_en = 1; parity_en = 0; parity_odd = 0;
    data_order = 0; polarity = 0; req_valid = '0; req_data = '0;
    refill = 0; tick_cnt = 0;
    mptr = N - 1; mgid = 0;
    @(negedge clk);
    do_reset();

    // single request, LSB first, 0xA5 from requester 2
    req_data[2*W +: W] = 8'hA5;
    req_valid = 4'b0100;
    obs.delete(); grants.delete();
    run_ticks(12, 4);
    chk("a5_frame", frame_val(0, 10), 32'h14B);
    chk("a5_winner", grants.size() > 0 ? grants[0] : -1, 32'd2);
    chk("a5_after", frame_val(10, 1), 32'd1);

    // even / odd parity on 0x07, then MSB-first 0x80
    parity_en = 1;
    req_data[0 +: W] = 8'h07; req_valid = 4'b0001;
    obs.delete();
    run_ticks(13, 3);
    chk("par_even", frame_val(9, 1), 32'd1);
    parity_odd = 1;
    req_data[1*W +: W] = 8'h07; req_valid = 4'b0010;
    obs.delete();
    run_ticks(13, 3);
    chk("par_odd", frame_val(9, 1), 32'd0);
    parity_en = 0; parity_odd = 0; data_order = 1;
    req_data[3*W +: W] = 8'h80; req_valid = 4'b1000;
    obs.delete();
    run_ticks(12, 3);
    chk("msb_first", frame_val(1, 2), 32'd2);
    data_order = 0;

    // inverted line
    polarity = 1;
    tick = 0;
    cycle(); cycle();
    chk("pol_idle", 32'(tx), 32'd0);
    req_data[2*W +: W] = 8'hA5; req_valid = 4'b0100;
    obs.delete();
    run_ticks(12, 4);
    chk("pol_frame", frame_val(0, 10), 32'h2B4);
    polarity = 0;
    run_ticks(2, 2);

    // reset in the middle of DATA, then fairness from requester 0
    req_data[1*W +: W] = 8'h3C; req_valid = 4'b0010;
    run_ticks(4, 4);
    tick = 0;
    cycle();
    chk("mid_busy", 32'(busy), 32'd1);
    do_reset();
    req_valid = 4'hF; refill = 1;
    grants.delete(); gtick.delete();
    run_ticks(81, 2);
    ok = (grants.size() >= 8);
    for (int i = 0; i < 8 && ok; i++) begin
      if (grants[i] != i % N) ok = 0;
      if (i > 0 && gtick[i] - gtick[i-1] != 10) ok = 0;
    end
    chk("first_after_rst", grants.size() > 0 ? grants[0] : -1, 32'd0);
    chk("rr_b2b", 32'(ok), 32'd1);
    refill = 0; req_valid = '0;
    run_ticks(12, 2);

    // tx_en dropped mid-frame
    req_valid = 4'b0001; refill = 1;
    grants.delete(); obs.delete();
    run_ticks(3, 3);
    tx_en = 0;
    run_ticks(20, 3);
    chk("en_grants", grants.size(), 32'd1);
    v = 0;
    for (int i = 10; i < 23; i++) v += int'(obs[i]);
    chk("en_idle_high", v, 32'd13);
    chk("en_busy", 32'(busy), 32'd0);
    refill = 0; req_valid = '0; tx_en = 1;

    // configuration changed mid-frame
    req_data[3*W +: W] = 8'hA5; req_valid = 4'b1000;
    obs.delete();
    run_ticks(3, 3);
    data_order = 1; parity_en = 1; parity_odd = 1;
    run_ticks(9, 3);
    chk("cfg_frame", frame_val(0, 10), 32'h14B);
    chk("cfg_after", frame_val(10, 1), 32'd1);
    data_order = 0; parity_en = 0; parity_odd = 0;

    // randomised traffic
    for (int c = 0; c < 4000; c++) begin
      tick = ($urandom % 3 == 0);
      if ($urandom % 60 == 0) parity_en = ~parity_en;
      if ($urandom % 60 == 0) parity_odd = ~parity_odd;
      if ($urandom % 60 == 0) data_order = ~data_order;
      if ($urandom % 80 == 0) polarity = ~polarity;
      tx_en = ($urandom % 30 != 0);
      refill = $urandom % 2;
      if ($urandom % 8 == 0) begin
        v = $urandom % N;
        req_valid[v] = ~req_valid[v];
        req_data[v*W +: W] = 8'($urandom);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit line between `NUM_REQ` byte producers and sequences each frame bit by bit. It sits between the requesters and the `tx_o` pad. Bit timing comes from the fractional baud generator's tick, `baud_tick_i`, which is one `clk_i` cycle wide. Each frame is start bit, data, optional parity, then stop bit, with configurable bit order and line polarity.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, data bits per frame

Ports:
- `clk_i`, input, 1, single clock
- `rst_ni`, input, 1, reset; asynchronous, active-low
- `baud_tick_i`, input, 1, one-cycle pulse per bit period
- `tx_en`, input, 1, allows new grants
- `parity_en`, input, 1, inserts a parity bit
- `parity_odd`, input, 1, 1 = odd parity, 0 = even
- `data_order`, input, 1, 1 = MSB first, 0 = LSB first
- `polarity`, input, 1, 1 = inverted line
- `req_valid_i`, input, `NUM_REQ`, byte pending per requester
- `req_data_i`, input, `NUM_REQ*DATA_WIDTH`, requester k occupies slice [k*DATA_WIDTH +: DATA_WIDTH]
- `req_ready_o`, output, `NUM_REQ`, one-hot accept pulse
- `grant_id_o`, output, $clog2(`NUM_REQ`), index of the current or last granted requester
- `busy_o`, output, 1, a frame is in progress
- `tx_o`, output, 1, serial line (registered)

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. Every state transition happens only in a cycle where `baud_tick_i`=1.
- Grant point:
  - a grant happens in a tick cycle while the FSM is in IDLE, or in the tick cycle that ends STOP;
  - it requires `tx_en`=1 and at least one `req_valid_i` bit set;
  - the winner is chosen round-robin: search starts at the requester after the last grantee and wraps modulo `NUM_REQ`.
- On a grant:
  - `req_ready_o[winner]`=1 for exactly that cycle; valid&ready is the transfer;
  - the data and `parity_en`, `parity_odd`, `data_order`, `polarity` are latched;
  - `grant_id_o` updates;
  - the next state is START.
- Line level before polarity: IDLE 1, START 0, DATA the current bit, PARITY the parity bit, STOP 1.
- `tx_o` = line ^ latched polarity. In IDLE, latched polarity tracks `polarity` every cycle.
- DATA runs a bit counter 0..`DATA_WIDTH`-1:
  - it advances one bit per tick;
  - it leaves to PARITY when `parity_en`=1, otherwise to STOP, after bit `DATA_WIDTH`-1.
- Parity bit = XOR of the data bits, inverted when `parity_odd`=1.
- STOP ends on a tick. It goes straight to START when a new grant occurs in that cycle (no idle gap), otherwise to IDLE.
- Deasserting `tx_en` mid-frame lets the current frame complete; no further grant is made.
- Configuration changes mid-frame have no effect until the next grant.
- `req_valid_i` dropping without a grant is legal; that requester is simply not considered.
- Reset, including mid-frame, immediately forces:
  - state IDLE;
  - `tx_o`=1, `busy_o`=0, `req_ready_o`=0, `grant_id_o`=0;
  - round-robin pointer = `NUM_REQ`-1, so requester 0 wins first;
  - the partially sent frame is abandoned.

## Timing
- Grant latency: `req_ready_o` pulses in the first tick cycle in which the FSM is in IDLE with the request visible.
- `tx_o` changes in the cycle after each tick (registered output). `busy_o` rises in the cycle after the grant.
- Each bit is held for exactly one tick period.
- Frame length is `DATA_WIDTH`+2 ticks, plus 1 tick with parity: 10 or 11 for 8 data bits.
- `busy_o` falls in the cycle after the tick that ends STOP, unless a back-to-back grant occurred in that tick.
- `baud_tick_i` arriving in two consecutive cycles advances two bits. Its period is the producer's responsibility.

## Structure
- `uart_pkg` holds the state enum `uart_tx_state_e` and the parity helper function. It is shared with the receive side.
- Sub-module `uart_rr_arbiter` is parameterised by `NUM_REQ`. Its ports:
  - inputs: request vector, an advance strobe;
  - outputs: one-hot grant, binary index, any-request flag.
- The rotating pointer lives in `uart_rr_arbiter`. The FSM, shifter and parity logic live in the top module.

## Test plan
- Single request, LSB first, no parity, polarity 0: requester 2 sends 0xA5. `tx_o` must show 0,1,0,1,0,0,1,0,1,1 over 10 ticks, and `req_ready_o`=4'b0100 for one cycle.
- Parity: 0x07 with parity_en=1. Even parity gives parity bit 1; odd gives 0. MSB first with 0x80 must give the first data bit 1.
- Polarity=1: idle `tx_o`=0, start bit 1, and every bit inverted relative to the polarity=0 run.
- Fairness: all 4 requesters held valid for 8 frames. Grants must go 0,1,2,3,0,1,2,3, back-to-back with no idle tick between frames.
- Boundaries:
  - `tx_en` dropped mid-frame: the frame completes, then `tx_o` stays 1 with no further grant;
  - config changed mid-frame: no effect on the frame in progress.
- Reset asserted mid-DATA: `tx_o`=1 and `busy_o`=0 immediately. After release, the first grant goes to requester 0.
